cdb_arb: RTL
============

Name: cdb_arb

Overview:
- Result-bus arbiter sitting between the functional units (ALU, MDU, LSU) and the common data bus (CDB).
- Buffers completed results per source in small FIFOs and grants one result per cycle onto a registered CDB.
- The CDB is broadcast to the reorder buffer and the reservation stations, so at most one write per cycle reaches them.
- Source index mapping: 0 = ALU, 1 = MDU, 2 = LSU.

Parameters:
- TAG_W, 4, width of a ROB tag; tag value 0 is reserved as "no tag".
- NUM_SRC, 3, number of result sources.
- BUF_DEPTH, 2, entries per source FIFO; power of two, at least 2.
- SRC_W, $clog2(NUM_SRC), width of the source index.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low (rst==0 resets on the rising clk edge).
- src_valid  in  NUM_SRC  source i presents a completed result.
- src_ready  out  NUM_SRC  source i FIFO can accept a result.
- src_tag  in  NUM_SRC*TAG_W  packed tags; source i occupies bits [i*TAG_W +: TAG_W].
- src_wdata  in  NUM_SRC*32  packed result data; source i occupies bits [i*32 +: 32].
- cdb_wr  out  1  CDB broadcast valid.
- cdb_tag  out  TAG_W  broadcast tag.
- cdb_wdata  out  32  broadcast data.
- cdb_src  out  SRC_W  index of the granted source (debug and monitor).

Behaviour:
- Reset (rst==0): all FIFOs empty, cdb_wr=0, cdb_tag=0, cdb_wdata=0, cdb_src=0, rr_ptr=0, src_ready=all 1s on the following cycle.
- Push: source i pushes when src_valid[i] && src_ready[i] at a rising edge.
- src_ready[i] = !full[i], driven from registered count only.
- No push-while-pop bypass: a full FIFO holds src_ready low for that cycle even if it is popped in the same cycle.
- Holding a result while src_ready is low is the source's responsibility; the arbiter never drops an accepted result.
- Arbitration: one round-robin pass per cycle over non-empty FIFOs, starting at rr_ptr and wrapping modulo NUM_SRC.
- The winner g is popped at the edge. rr_ptr <= (g+1) mod NUM_SRC; rr_ptr is unchanged when no FIFO is non-empty.
- Output register:
  - On a grant: cdb_wr<=1, cdb_tag<=head tag, cdb_wdata<=head data, cdb_src<=g.
  - With no grant: cdb_wr<=0; cdb_tag and cdb_wdata hold their previous values.
  - cdb_wr is high for exactly one cycle per popped entry.
- Latency: a handshake in cycle c makes cdb_wr high in cycle c+2 when uncontended. Sustained throughput is 1 result per cycle.
- Simultaneous push and pop on the same FIFO: count is unchanged; pointers advance modulo BUF_DEPTH.
- Empty FIFO: not a grant candidate; the head contents are don't-care.
- FIFO ordering: entries leave each FIFO in FIFO order. There is no ordering guarantee across sources.
- Reset mid-operation: all buffered results are discarded and cdb_wr=0 the next cycle. No partial broadcast.
- Tag 0: src_valid with src_tag==0 is illegal; a simulation assertion fires. If it occurs, the RTL still forwards the entry.
- Width rules: FIFO count is $clog2(BUF_DEPTH)+1 bits. rr_ptr is SRC_W bits and wraps explicitly at NUM_SRC, not at 2^SRC_W.

Decomposition:
- Shared package rv32i_types holds:
  - cdb_pkt_t, a packed struct {tag [TAG_W-1:0], wdata [31:0]};
  - localparams SRC_ALU=0, SRC_MDU=1, SRC_LSU=2.
- Sub-module cdb_fifo (parameters WIDTH, DEPTH): synchronous, active-low reset, push/pop/full/empty/head. Instantiated NUM_SRC times in a generate loop.
- Round-robin selection stays inline in cdb_arb.

Test Plan:
1. Reset and idle: rst=0 for 2 cycles, then rst=1, no stimulus → cdb_wr=0, cdb_tag=0, src_ready=3'b111 every cycle.
2. Single result: ALU pushes tag 3, data 0xDEAD_BEEF in cycle 5 → cdb_wr=1, tag=3, data=0xDEADBEEF, src=0 in cycle 7 only.
3. Three-way contention: all sources push in the same cycle (tags 1, 2, 3) after reset → broadcasts in order src 0, 1, 2 on consecutive cycles. rr_ptr then returns to 0.
4. Backpressure: MDU pushes tags 4, 5, 6 on consecutive cycles while ALU streams continuously.
   - src_ready[1] drops when the MDU FIFO holds 2 entries.
   - Tag 6 is accepted only after ready returns.
   - MDU tags broadcast in order 4, 5, 6; none is lost or duplicated.
5. Fairness: ALU and LSU both push every cycle for 20 cycles → CDB grants alternate 0, 2, 0, 2. Neither source is starved for more than 1 cycle.
6. Reset mid-operation: with 2 entries buffered in each FIFO, pulse rst=0 for 1 cycle → cdb_wr=0 the next cycle and no buffered tag is ever broadcast afterward.

Source files
------------

// File: rtl/rv32i_types.sv
// Purpose : shared types and constants for the result-bus (CDB) path.
// Latency : n/a (types only).
// Backpressure : n/a (types only).
// Contents: CDB packet struct (tag + data) and the fixed source indices.
package rv32i_types;

   // ROB tag width carried on the CDB; tag value 0 means "no tag".
   localparam int CDB_TAG_W = 4;

   // Result source indices on the arbiter inputs.
   localparam int SRC_ALU = 0;
   localparam int SRC_MDU = 1;
   localparam int SRC_LSU = 2;

   typedef struct packed {
      logic [CDB_TAG_W-1:0] tag;
      logic [31:0]          wdata;
   } cdb_pkt_t;

endpackage

// File: rtl/cdb_fifo.sv
// Purpose : small per-source result buffer in front of the CDB arbiter.
// Latency : a push is visible at head the cycle after the push edge.
// Backpressure : full is derived from the registered count only, so a pop
//                in the same cycle does not reopen the FIFO until next cycle.
// Ports   : clk, rst (sync, active-low), push/push_dat (write side),
//           pop (read side), full, empty, head (current oldest entry).
module cdb_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   // Head is don't-care while empty; the arbiter never selects an empty FIFO.
   assign head    = mem[rd_ptr];

   // Storage needs no reset: nothing is read until count says it is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/cdb_arb.sv
// Purpose : round-robin arbiter of ALU/MDU/LSU results onto a registered CDB.
// Latency : handshake in cycle c -> cdb_wr in cycle c+2 when uncontended; 1/cycle sustained.
// Backpressure : src_ready[i] = !full[i] from registered state; sources hold while low.
// Ports   : clk, rst (sync, active-low); src_valid/src_ready/src_tag/src_wdata
//           (packed per source, index 0=ALU 1=MDU 2=LSU); cdb_wr/cdb_tag/
//           cdb_wdata broadcast to ROB and reservation stations; cdb_src = winner.
module cdb_arb
   import rv32i_types::*;
#(
   parameter int TAG_W     = CDB_TAG_W,  // must match the package packet tag width
   parameter int NUM_SRC   = SRC_LSU + 1,
   parameter int BUF_DEPTH = 2,
   parameter int SRC_W     = $clog2(NUM_SRC)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_SRC-1:0]       src_valid,
   output logic [NUM_SRC-1:0]       src_ready,
   input  logic [NUM_SRC*TAG_W-1:0] src_tag,
   input  logic [NUM_SRC*32-1:0]    src_wdata,
   output logic                     cdb_wr,
   output logic [TAG_W-1:0]         cdb_tag,
   output logic [31:0]              cdb_wdata,
   output logic [SRC_W-1:0]         cdb_src
);

   localparam logic [SRC_W:0]   NUM_SRC_X = (SRC_W+1)'(NUM_SRC);
   localparam logic [SRC_W-1:0] LAST_SRC  = SRC_W'(NUM_SRC - 1);

   cdb_pkt_t           head [NUM_SRC];
   logic [NUM_SRC-1:0] full;
   logic [NUM_SRC-1:0] empty;
   logic [NUM_SRC-1:0] push;
   logic [NUM_SRC-1:0] pop;
   logic [SRC_W-1:0]   rr_ptr;
   logic [SRC_W-1:0]   grant_idx;
   logic               grant_vld;
   logic [SRC_W:0]     cand;

   assign src_ready = ~full;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      cdb_pkt_t in_pkt;

      assign in_pkt.tag   = src_tag[i*TAG_W +: TAG_W];
      assign in_pkt.wdata = src_wdata[i*32 +: 32];
      assign push[i]      = src_valid[i] & ~full[i];
      assign pop[i]       = grant_vld && (grant_idx == SRC_W'(i));

      cdb_fifo #(
         .WIDTH ($bits(cdb_pkt_t)),
         .DEPTH (BUF_DEPTH)
      ) u_fifo (
         .clk      (clk),
         .rst      (rst),
         .push     (push[i]),
         .push_dat (in_pkt),
         .pop      (pop[i]),
         .full     (full[i]),
         .empty    (empty[i]),
         .head     (head[i])
      );

      // Tag 0 means "no tag" downstream; a source must never present it.
      a_tag_nonzero: assert property (@(posedge clk) disable iff (!rst)
         src_valid[i] |-> (src_tag[i*TAG_W +: TAG_W] != '0));
   end

   // One round-robin pass starting at rr_ptr. rr_ptr and k are both below
   // NUM_SRC, so a single conditional subtract wraps the candidate index.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         cand = {1'b0, rr_ptr} + (SRC_W+1)'(k);
         if (cand >= NUM_SRC_X) begin
            cand = cand - NUM_SRC_X;
         end
         if (!grant_vld && !empty[cand[SRC_W-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = cand[SRC_W-1:0];
         end
      end
   end

   // Registered CDB: tag/data hold on idle cycles, only cdb_wr marks a write.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_ptr    <= SRC_W'(SRC_ALU);
         cdb_wr    <= 1'b0;
         cdb_tag   <= '0;
         cdb_wdata <= '0;
         cdb_src   <= '0;
      end else begin
         cdb_wr <= grant_vld;
         if (grant_vld) begin
            cdb_tag   <= head[grant_idx].tag;
            cdb_wdata <= head[grant_idx].wdata;
            cdb_src   <= grant_idx;
            // Explicit wrap at NUM_SRC, not at 2^SRC_W.
            rr_ptr    <= (grant_idx == LAST_SRC) ? '0 : grant_idx + SRC_W'(1);
         end
      end
   end

endmodule
